// File: rtl/barrel_shifter_seq_right.sv
// Sequential right shifter/rotator: one logarithmic stage per clock, valid/ready on both sides.
// Stage k shifts the work register by 2^k when the captured shamt[k] is set.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for an operand, in_ready=1
//  ST_SHIFT | applying stage stage_q to the work register
//  ST_DONE  | result held on data_out with out_valid=1 until out_ready

module barrel_shifter_seq_right #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     MODE_LSR   = 2'b00;
    localparam logic [1:0]     MODE_ASR   = 2'b01;
    localparam logic [1:0]     MODE_ROR   = 2'b10;
    localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   stage_q, stage_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [1:0]       mode_q, mode_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] stage_res;

    // Only the stage selected by stage_q contributes; each is a fixed-distance shift.
    always_comb begin
        stage_res = work_q;
        for (int k = 0; k < SHW; k++) begin
            if (stage_q == SHW'(k) && shamt_q[k]) begin
                case (mode_q)
                    MODE_ASR: stage_res = WIDTH'($signed(work_q) >>> (2 ** k));
                    MODE_ROR: stage_res = (work_q >> (2 ** k)) | (work_q << (WIDTH - 2 ** k));
                    default:  stage_res = work_q >> (2 ** k);
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        work_d      = work_q;
        shamt_d     = shamt_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d     = data_in;
                    shamt_d    = shamt;
                    mode_d     = (mode == 2'b11) ? MODE_LSR : mode;
                    stage_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = stage_res;
                if (stage_q == LAST_STAGE) begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            work_q      <= '0;
            shamt_q     <= '0;
            mode_q      <= MODE_LSR;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            work_q      <= work_d;
            shamt_q     <= shamt_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = work_q;

endmodule

// File: tb/tb_barrel_shifter_seq_right.sv
// Bench for barrel_shifter_seq_right: directed cases from hand-worked values plus a
// randomized run, all checked against an arithmetic reference and a per-cycle handshake model.

module tb_barrel_shifter_seq_right;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic [S-1:0] shamt;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;

    int total = 0;
    int bad   = 0;

    barrel_shifter_seq_right #(.WIDTH(W), .SHW(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                               input logic [1:0] md);
        logic [2*W-1:0] dd;
        case (md)
            2'b01:   return W'($signed(d) >>> sh);
            2'b10: begin
                dd = {d, d} >> sh;
                return dd[W-1:0];
            end
            default: return d >> sh;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: phase 0 idle, 1 shifting, 2 result held.
    int           m_phase;
    int           m_cnt;
    logic [W-1:0] m_res;
    logic [W-1:0] m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
            m_last  <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_cnt   <= S;
                    m_res   <= ref_shift(data_in, int'(shamt), mode);
                end
                1: if (m_cnt == 1) begin
                    m_phase <= 2;
                    m_last  <= m_res;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("model_out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase == 2) chk("model_data_done", 32'(data_out), 32'(m_res));
            if (m_phase == 0) chk("model_data_idle", 32'(data_out), 32'(m_last));
        end
    end

    task automatic run_op(input logic [W-1:0] d, input int sh, input logic [1:0] md,
                          input logic [W-1:0] exp, input int stall);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_op", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in  = d;
        shamt    = S'(sh);
        mode     = md;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = W'($urandom);
        shamt    = S'($urandom);
        mode     = 2'($urandom);
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(S));
        chk("result", 32'(data_out), 32'(exp));
        // Stalled consumer: toggle ignored inputs, result must hold.
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            data_in  = W'($urandom);
            shamt    = S'($urandom);
            mode     = 2'($urandom);
            @(negedge clk);
            chk("hold_data", 32'(data_out), 32'(exp));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_ready", 32'(in_ready), 32'd1);
        chk("release_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        int           sh;
        logic [1:0]   md;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        shamt     = '0;
        mode      = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("pin_lsr", 32'(ref_shift(8'hB2, 3, 2'b00)), 32'h16);
        chk("pin_asr", 32'(ref_shift(8'hB2, 3, 2'b01)), 32'hF6);
        chk("pin_ror", 32'(ref_shift(8'hB2, 3, 2'b10)), 32'h56);
        chk("pin_m11", 32'(ref_shift(8'hB2, 3, 2'b11)), 32'h16);
        chk("pin_ror7", 32'(ref_shift(8'h81, 7, 2'b10)), 32'h03);

        run_op(8'hB2, 3, 2'b00, 8'h16, 0);
        run_op(8'hB2, 3, 2'b01, 8'hF6, 0);
        run_op(8'hB2, 3, 2'b10, 8'h56, 1);
        run_op(8'hB2, 3, 2'b11, 8'h16, 0);
        run_op(8'hFF, 7, 2'b00, 8'h01, 0);
        run_op(8'h80, 7, 2'b01, 8'hFF, 0);
        run_op(8'h81, 7, 2'b10, 8'h03, 0);
        run_op(8'h5A, 0, 2'b00, 8'h5A, 0);
        run_op(8'h5A, 0, 2'b10, 8'h5A, 0);
        run_op(8'hC3, 5, 2'b01, 8'hFE, 5);
        run_op(8'h12, 4, 2'b10, 8'h21, 0);

        // Asynchronous reset one cycle into the shift.
        in_valid = 1'b1;
        data_in  = 8'hE7;
        shamt    = 3'd1;
        mode     = 2'b01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h3C, 2, 2'b00, 8'h0F, 0);

        for (int i = 0; i < 200; i++) begin
            d  = W'($urandom);
            sh = $urandom_range(0, W - 1);
            md = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(d, sh, md, ref_shift(d, sh, md), $urandom_range(0, 4));
        end

        repeat (2) @(negedge clk);
        if (bad == 0) $display("Congratulation! You Pass!");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
